mult32x32_dispatch: RTL and testbench



---
 rtl/mult_pkg.sv | 26 ++
 rtl/op_fifo.sv | 82 ++++++++
 rtl/mult32x32_dispatch.sv | 145 ++++++++++++++
 tb/tb_mult32x32_dispatch.sv | 338 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mult_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : mult_pkg
//  Description : Shared types for the mult32x32 dispatcher: operand and
//                product widths, and the dispatcher FSM state encoding.
//  Revision    : 1.0 - initial release
// ============================================================================
package mult_pkg;

    localparam int OPW   = 32;
    localparam int PRODW = 64;

    typedef logic [OPW-1:0]   operand_t;
    typedef logic [PRODW-1:0] product_t;

    // IDLE  : waiting for a queued pair and a free output register
    // START : one-cycle start pulse to the multiplier
    // RUN   : operands held until the multiplier drops busy
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        RUN   = 2'd2
    } disp_state_t;

endpackage : mult_pkg
`default_nettype wire

// File: rtl/op_fifo.sv
`default_nettype none
// ============================================================================
//  Module      : op_fifo
//  Description : Synchronous FIFO of {a,b} operand pairs with occupancy
//                count. Pushes into a full FIFO and pops from an empty one
//                are ignored. Pointers wrap modulo DEPTH (power of two).
//  Ports       : clk, reset (async, active-high)
//                push, push_a, push_b   - write side
//                pop, head_a, head_b    - read side (head is show-ahead)
//                full, empty, count     - status, all from registered state
//  Revision    : 1.0 - initial release
// ============================================================================
module op_fifo
    import mult_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int CNT_W = $clog2(DEPTH) + 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push,
    input  operand_t         push_a,
    input  operand_t         push_b,
    input  logic             pop,
    output operand_t         head_a,
    output operand_t         head_b,
    output logic             full,
    output logic             empty,
    output logic [CNT_W-1:0] count
);

    localparam int PTR_W = $clog2(DEPTH);

    operand_t           r_mem_a [DEPTH];
    operand_t           r_mem_b [DEPTH];
    logic [PTR_W-1:0]   r_wptr;
    logic [PTR_W-1:0]   r_rptr;
    logic [CNT_W-1:0]   r_count;

    logic w_do_push;
    logic w_do_pop;

    // Status comes from the registered count only, so a full FIFO refuses a
    // push even in the cycle it is being popped.
    assign full      = (r_count == CNT_W'(DEPTH));
    assign empty     = (r_count == '0);
    assign count     = r_count;
    assign w_do_push = push && !full;
    assign w_do_pop  = pop && !empty;
    assign head_a    = r_mem_a[r_rptr];
    assign head_b    = r_mem_b[r_rptr];

    // Storage carries no reset; only pointers and count define validity.
    always_ff @(posedge clk) begin
        if (w_do_push) begin
            r_mem_a[r_wptr] <= push_a;
            r_mem_b[r_wptr] <= push_b;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else begin
            if (w_do_push) begin
                r_wptr <= r_wptr + PTR_W'(1);
            end
            if (w_do_pop) begin
                r_rptr <= r_rptr + PTR_W'(1);
            end
            case ({w_do_push, w_do_pop})
                2'b10:   r_count <= r_count + CNT_W'(1);
                2'b01:   r_count <= r_count - CNT_W'(1);
                default: r_count <= r_count;
            endcase
        end
    end

endmodule : op_fifo
`default_nettype wire

// File: rtl/mult32x32_dispatch.sv
`default_nettype none
// ============================================================================
//  Module      : mult32x32_dispatch
//  Description : Buffers a/b operand pairs from a valid/ready producer,
//                issues them one at a time to mult32x32 using its start/busy
//                protocol, and returns each 64-bit product through a
//                valid/ready consumer port. At most one result is in flight.
//  Ports       : clk, reset (async, active-high)
//                in_valid/in_ready/in_a/in_b        - operand input
//                out_valid/out_ready/out_product    - result output
//                mult_start/mult_a/mult_b           - to mult32x32
//                mult_busy/mult_product             - from mult32x32
//                fifo_count                         - operand FIFO occupancy
//  Revision    : 1.0 - initial release
// ============================================================================
module mult32x32_dispatch
    import mult_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int CNT_W = $clog2(DEPTH) + 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [31:0]      in_a,
    input  logic [31:0]      in_b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [63:0]      out_product,
    output logic             mult_start,
    output logic [31:0]      mult_a,
    output logic [31:0]      mult_b,
    input  logic             mult_busy,
    input  logic [63:0]      mult_product,
    output logic [CNT_W-1:0] fifo_count
);

    disp_state_t r_state;
    disp_state_t w_state_nxt;

    operand_t    r_mult_a;
    operand_t    r_mult_b;
    product_t    r_out_product;
    logic        r_out_valid;

    logic        w_push;
    logic        w_issue;
    logic        w_capture;
    logic        w_full;
    logic        w_empty;
    operand_t    w_head_a;
    operand_t    w_head_b;

    assign in_ready    = !w_full;
    assign w_push      = in_valid && !w_full;

    op_fifo #(
        .DEPTH (DEPTH),
        .CNT_W (CNT_W)
    ) u_op_fifo (
        .clk    (clk),
        .reset  (reset),
        .push   (w_push),
        .push_a (in_a),
        .push_b (in_b),
        .pop    (w_issue),
        .head_a (w_head_a),
        .head_b (w_head_b),
        .full   (w_full),
        .empty  (w_empty),
        .count  (fifo_count)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Issue is gated by the registered out_valid, so a new operation starts
    // the cycle after the previous result is consumed. mult_busy is not
    // looked at outside RUN.
    always_comb begin
        w_state_nxt = r_state;
        w_issue     = 1'b0;
        w_capture   = 1'b0;
        case (r_state)
            IDLE: begin
                if (!w_empty && !r_out_valid) begin
                    w_issue     = 1'b1;
                    w_state_nxt = START;
                end
            end
            START: begin
                w_state_nxt = RUN;
            end
            RUN: begin
                // busy rises the cycle after start, so the first RUN cycle
                // already sees it high; low here means the product is ready.
                if (!mult_busy) begin
                    w_capture   = 1'b1;
                    w_state_nxt = IDLE;
                end
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    // Decoded from the state register so reset removes the pulse immediately.
    assign mult_start = (r_state == START);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_mult_a <= '0;
            r_mult_b <= '0;
        end else if (w_issue) begin
            r_mult_a <= w_head_a;
            r_mult_b <= w_head_b;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_out_valid   <= 1'b0;
            r_out_product <= '0;
        end else if (w_capture) begin
            r_out_valid   <= 1'b1;
            r_out_product <= mult_product;
        end else if (r_out_valid && out_ready) begin
            r_out_valid   <= 1'b0;
        end
    end

    assign mult_a      = r_mult_a;
    assign mult_b      = r_mult_b;
    assign out_valid   = r_out_valid;
    assign out_product = r_out_product;

endmodule : mult32x32_dispatch
`default_nettype wire

// File: tb/tb_mult32x32_dispatch.sv
`default_nettype none
// ============================================================================
//  Module      : tb_mult32x32_dispatch
//  Description : Self-checking bench for mult32x32_dispatch with a behavioural
//                mult32x32 (busy for 4 cycles, product sampled from the held
//                operands at the end of the operation).
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_mult32x32_dispatch;
    import mult_pkg::*;

    localparam int DEPTH = 4;
    localparam int CNT_W = $clog2(DEPTH) + 1;

    logic             clk = 1'b0;
    logic             reset;
    logic             in_valid;
    logic             in_ready;
    logic [31:0]      in_a;
    logic [31:0]      in_b;
    logic             out_valid;
    logic             out_ready;
    logic [63:0]      out_product;
    logic             mult_start;
    logic [31:0]      mult_a;
    logic [31:0]      mult_b;
    logic             mult_busy;
    logic [63:0]      mult_product;
    logic [CNT_W-1:0] fifo_count;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    mult32x32_dispatch #(.DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
        .clk          (clk),
        .reset        (reset),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .in_a         (in_a),
        .in_b         (in_b),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .out_product  (out_product),
        .mult_start   (mult_start),
        .mult_a       (mult_a),
        .mult_b       (mult_b),
        .mult_busy    (mult_busy),
        .mult_product (mult_product),
        .fifo_count   (fifo_count)
    );

    // ---------------- behavioural multiplier ----------------
    logic [2:0] m_cnt;
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            mult_busy    <= 1'b0;
            m_cnt        <= '0;
            mult_product <= '0;
        end else if (mult_busy) begin
            if (m_cnt == 3'd0) begin
                mult_busy    <= 1'b0;
                mult_product <= 64'(mult_a) * 64'(mult_b);
            end else begin
                m_cnt <= m_cnt - 3'd1;
            end
        end else if (mult_start) begin
            mult_busy <= 1'b1;
            m_cnt     <= 3'd3;
        end
    end

    // ---------------- protocol monitors ----------------
    int         starts   = 0;
    int         doubles  = 0;
    int         overlaps = 0;
    int         unstable = 0;
    logic       prev_start = 1'b0;
    logic [31:0] held_a = '0;
    logic [31:0] held_b = '0;

    always @(posedge clk) begin
        if (mult_start) begin
            starts <= starts + 1;
            held_a <= mult_a;
            held_b <= mult_b;
            if (prev_start) doubles <= doubles + 1;
            if (mult_busy) overlaps <= overlaps + 1;
        end else if (mult_busy && (mult_a != held_a || mult_b != held_b)) begin
            unstable <= unstable + 1;
        end
        prev_start <= mult_start;
    end

    // ---------------- helpers ----------------
    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push_one(input logic [31:0] a, input logic [31:0] b);
        bit ok = 0;
        in_valid = 1'b1;
        in_a = a;
        in_b = b;
        for (int i = 0; i < 200; i++) begin
            if (in_ready) begin
                ok = 1;
                break;
            end
            tick();
        end
        if (!ok) begin
            total++;
            bad++;
            $display("FAIL push_timeout: in_ready stayed 0, required 1");
        end
        tick();
        in_valid = 1'b0;
    endtask

    // Waits for out_valid, compares, then lets one edge consume it
    // (out_ready is expected to be 1 at the call).
    task automatic expect_result(input string name, input logic [63:0] exp);
        bit ok = 0;
        for (int i = 0; i < 100; i++) begin
            if (out_valid) begin
                ok = 1;
                break;
            end
            tick();
        end
        if (!ok) begin
            total++;
            bad++;
            $display("FAIL %s: out_valid never rose, required product %h", name, exp);
        end else begin
            check(name, out_product, exp);
            tick();
        end
    endtask

    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        logic [63:0] exp;
    } vec_t;

    vec_t vecs [6];

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int s0;
        int acc;
        int seen;
        bit ok;

        vecs[0] = '{32'h0C46B736, 32'h1302BF7F, 64'd65690688518499786};
        vecs[1] = '{32'hFFFFFFFF, 32'hFFFFFFFF, 64'hFFFFFFFE00000001};
        vecs[2] = '{32'h00000000, 32'h12345678, 64'h0};
        vecs[3] = '{32'h00000001, 32'hFFFFFFFF, 64'h00000000FFFFFFFF};
        vecs[4] = '{32'h80000000, 32'h00000002, 64'h0000000100000000};
        vecs[5] = '{32'h00010000, 32'h00010000, 64'h0000000100000000};

        reset     = 1'b1;
        in_valid  = 1'b0;
        in_a      = '0;
        in_b      = '0;
        out_ready = 1'b0;
        tick();
        tick();

        // ---- reset values ----
        check("rst_in_ready",    64'(in_ready),    64'd1);
        check("rst_out_valid",   64'(out_valid),   64'd0);
        check("rst_out_product", out_product,      64'd0);
        check("rst_mult_start",  64'(mult_start),  64'd0);
        check("rst_mult_a",      64'(mult_a),      64'd0);
        check("rst_mult_b",      64'(mult_b),      64'd0);
        check("rst_fifo_count",  64'(fifo_count), 64'd0);
        reset = 1'b0;
        tick();

        // ---- single op: latency, pulse shape, operand hold ----
        out_ready = 1'b1;
        s0 = starts;
        in_valid = 1'b1;
        in_a = 32'h0C46B736;
        in_b = 32'h1302BF7F;
        tick();
        in_valid = 1'b0;
        check("lat_count_after_push", 64'(fifo_count), 64'd1);
        check("lat_no_start_yet",     64'(mult_start), 64'd0);
        tick();
        check("lat_start_pulse",      64'(mult_start), 64'd1);
        check("lat_mult_a",           64'(mult_a),     64'h0C46B736);
        check("lat_mult_b",           64'(mult_b),     64'h1302BF7F);
        check("lat_count_after_pop",  64'(fifo_count), 64'd0);
        tick();
        check("lat_start_one_cycle",  64'(mult_start), 64'd0);
        check("lat_busy_after_start", 64'(mult_busy),  64'd1);
        expect_result("single_product", 64'd65690688518499786);
        check("single_start_count", 64'(starts - s0), 64'd1);

        // ---- table of directed vectors ----
        for (int i = 0; i < 6; i++) begin
            push_one(vecs[i].a, vecs[i].b);
            expect_result($sformatf("vec%0d", i), vecs[i].exp);
        end

        // ---- back-to-back pushes, ordered results ----
        s0 = starts;
        in_valid = 1'b1;
        in_a = 32'hFFFFFFFF;
        in_b = 32'hFFFFFFFF;
        tick();
        in_a = 32'h00000000;
        in_b = 32'h12345678;
        tick();
        in_valid = 1'b0;
        expect_result("b2b_first",  64'hFFFFFFFE00000001);
        expect_result("b2b_second", 64'h0);
        check("b2b_start_count", 64'(starts - s0), 64'd2);

        // ---- fill with output stalled ----
        // The first pair is issued straight away, so DEPTH+1 pairs are taken
        // before the queue fills; the next one must be refused.
        out_ready = 1'b0;
        s0  = starts;
        acc = 0;
        for (int k = 1; k <= DEPTH + 2; k++) begin
            in_a = 32'(k);
            in_b = 32'(k);
            in_valid = 1'b1;
            if (!in_ready) break;
            tick();
            acc++;
        end
        check("fill_accepted", 64'(acc), 64'(DEPTH + 1));
        check("fill_count_full", 64'(fifo_count), 64'(DEPTH));
        check("fill_in_ready_low", 64'(in_ready), 64'd0);
        ok = 0;
        for (int i = 0; i < 100; i++) begin
            if (out_valid) begin
                ok = 1;
                break;
            end
            tick();
        end
        check("fill_result_ready", 64'(ok), 64'd1);
        tick();
        tick();
        tick();
        check("fill_product_hold", out_product, 64'd1);
        check("fill_valid_hold",   64'(out_valid), 64'd1);
        check("fill_count_hold",   64'(fifo_count), 64'(DEPTH));
        check("fill_one_issue",    64'(starts - s0), 64'd1);

        // ---- full FIFO: pop with a refused push, then the push lands ----
        out_ready = 1'b1;           // in_valid still high with pair 6x6
        tick();                     // result 1 consumed
        check("full_consumed",     64'(out_valid), 64'd0);
        check("full_no_pop_yet",   64'(fifo_count), 64'(DEPTH));
        tick();                     // issue pops, push refused (was full)
        check("full_pop_count",    64'(fifo_count), 64'(DEPTH - 1));
        check("full_pop_start",    64'(mult_start), 64'd1);
        tick();                     // push of 6x6 accepted
        check("full_refill_count", 64'(fifo_count), 64'(DEPTH));
        in_valid = 1'b0;
        expect_result("drain_4",  64'd4);
        expect_result("drain_9",  64'd9);
        expect_result("drain_16", 64'd16);
        expect_result("drain_25", 64'd25);
        expect_result("drain_36", 64'd36);
        check("drain_empty", 64'(fifo_count), 64'd0);
        check("monitor_double_start", 64'(doubles),  64'd0);
        check("monitor_overlap",      64'(overlaps), 64'd0);
        check("monitor_unstable",     64'(unstable), 64'd0);

        // ---- reset during RUN with two entries queued ----
        in_valid = 1'b1;
        in_a = 32'd3;  in_b = 32'd5;  tick();
        in_a = 32'd7;  in_b = 32'd9;  tick();
        in_a = 32'd11; in_b = 32'd13; tick();
        in_valid = 1'b0;
        ok = 0;
        for (int i = 0; i < 20; i++) begin
            if (mult_busy) begin
                ok = 1;
                break;
            end
            tick();
        end
        check("rr_in_run", 64'(ok), 64'd1);
        check("rr_queued", 64'(fifo_count), 64'd2);
        reset = 1'b1;
        #1;
        check("rr_fifo_count",  64'(fifo_count), 64'd0);
        check("rr_mult_start",  64'(mult_start), 64'd0);
        check("rr_mult_a",      64'(mult_a),     64'd0);
        check("rr_mult_b",      64'(mult_b),     64'd0);
        check("rr_out_valid",   64'(out_valid),  64'd0);
        check("rr_out_product", out_product,     64'd0);
        check("rr_in_ready",    64'(in_ready),   64'd1);
        tick();
        tick();
        reset = 1'b0;
        s0 = starts;
        seen = 0;
        for (int i = 0; i < 20; i++) begin
            if (out_valid) seen++;
            tick();
        end
        check("rr_no_result_after", 64'(seen), 64'd0);
        check("rr_no_issue_after",  64'(starts - s0), 64'd0);
        push_one(32'd6, 32'd7);
        expect_result("rr_new_op", 64'd42);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule : tb_mult32x32_dispatch
`default_nettype wire
